// File: rtl/bran_pred_ctrl.sv
// Pipeline-side branch predictor controller: drives lookups, picks the next fetch PC,
// tracks in-flight predictions until EX resolves them, then trains the predictor and flushes on mispredict.
module bran_pred_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            fetch_en,
  input  logic [31:0]     fetch_pc,
  input  logic            hit,
  input  logic            pc_bran_pred,
  input  logic [29:0]     branaddr_out,
  output logic [29:0]     addr2,
  output logic [31:0]     next_pc,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_taken,
  input  logic [31:0]     ex_target,
  output logic            branEN,
  output logic            take,
  output logic [31:0]     addr1,
  output logic [29:0]     branaddr_in,
  output logic            flush,
  output logic            full,
  output logic [CNTW-1:0] mispred_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic [29:0] target;
  } entry_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  entry_t         q_mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_d;
  state_t         state_q;
  state_t         state_d;
  logic [31:0]    redirect_pc;

  entry_t         head;
  logic           pred;
  logic           push;
  logic           pop;
  logic           mispred;
  logic [31:0]    correct_pc;

  assign addr2 = fetch_pc[31:2];
  assign pred  = hit & pc_bran_pred;
  assign head  = q_mem[rd_ptr];

  // Next fetch PC: pending redirect beats prediction beats sequential.
  always_comb begin
    next_pc = fetch_pc + 32'd4;
    if (flush) begin
      next_pc = redirect_pc;
    end else if (pred) begin
      next_pc = {branaddr_out, 2'b00};
    end
  end

  // Queue control, head evaluation and FSM next state.
  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    mispred    = 1'b0;
    correct_pc = head.pc + 32'd4;
    count_d    = count;
    state_d    = state_q;

    if (ex_branch) begin
      mispred = (head.pred != ex_taken) ||
                (ex_taken && head.pred && (head.target != ex_target[31:2]));
    end else begin
      mispred = head.pred;
    end

    if (ex_branch && ex_taken) begin
      correct_pc = ex_target;
    end

    case (state_q)
      S_RUN: begin
        push = fetch_en && !full;
        pop  = ex_valid && (count != CW'(0));
        case ({push, pop})
          2'b10:   count_d = count + CW'(1);
          2'b01:   count_d = count - CW'(1);
          default: count_d = count;
        endcase
        if (pop && mispred) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        count_d = CW'(0);
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_RUN;
      flush   <= 1'b0;
    end else begin
      state_q <= state_d;
      flush   <= (state_d == S_FLUSH);
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_mem[wr_ptr] <= '{pc: fetch_pc, pred: pred, target: branaddr_out};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      if (state_q == S_FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Predictor training follows every resolved branch by one cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branEN      <= 1'b0;
      take        <= 1'b0;
      addr1       <= '0;
      branaddr_in <= '0;
    end else begin
      branEN <= pop && ex_branch;
      if (pop && ex_branch) begin
        take        <= ex_taken;
        addr1       <= head.pc;
        branaddr_in <= ex_target[31:2];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redirect_pc <= '0;
      mispred_cnt <= '0;
    end else if (pop && mispred) begin
      redirect_pc <= correct_pc;
      if (mispred_cnt != {CNTW{1'b1}}) begin
        mispred_cnt <= mispred_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bran_pred_ctrl.sv
// Directed bench for bran_pred_ctrl; a second instance with a 4-bit counter checks saturation.
module tb_bran_pred_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic        hit;
  logic        pc_bran_pred;
  logic [29:0] branaddr_out;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_taken;
  logic [31:0] ex_target;

  logic [29:0] addr2, addr2_4;
  logic [31:0] next_pc, next_pc_4;
  logic        branEN, branEN_4;
  logic        take, take_4;
  logic [31:0] addr1, addr1_4;
  logic [29:0] branaddr_in, branaddr_in_4;
  logic        flush, flush_4;
  logic        full, full_4;
  logic [15:0] mispred_cnt;
  logic [3:0]  mispred_cnt_4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  bran_pred_ctrl #(.DEPTH(4), .CNTW(16)) dut (
    .CLK(CLK), .nRST(nRST), .fetch_en(fetch_en), .fetch_pc(fetch_pc), .hit(hit),
    .pc_bran_pred(pc_bran_pred), .branaddr_out(branaddr_out), .addr2(addr2), .next_pc(next_pc),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .branEN(branEN), .take(take), .addr1(addr1), .branaddr_in(branaddr_in), .flush(flush),
    .full(full), .mispred_cnt(mispred_cnt)
  );

  bran_pred_ctrl #(.DEPTH(4), .CNTW(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .fetch_en(fetch_en), .fetch_pc(fetch_pc), .hit(hit),
    .pc_bran_pred(pc_bran_pred), .branaddr_out(branaddr_out), .addr2(addr2_4), .next_pc(next_pc_4),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .branEN(branEN_4), .take(take_4), .addr1(addr1_4), .branaddr_in(branaddr_in_4), .flush(flush_4),
    .full(full_4), .mispred_cnt(mispred_cnt_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; fetch_en = 1'b0; fetch_pc = '0; hit = 1'b0; pc_bran_pred = 1'b0;
    branaddr_out = '0; ex_valid = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    #2;
    chk("rst_branEN", {31'd0, branEN}, 32'd0);
    chk("rst_take", {31'd0, take}, 32'd0);
    chk("rst_addr1", addr1, 32'd0);
    chk("rst_branaddr_in", {2'd0, branaddr_in}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_cnt", {16'd0, mispred_cnt}, 32'd0);
    chk("rst4_all", {addr1_4[7:0], 2'd0, branaddr_in_4[7:0], 8'd0, mispred_cnt_4,
                     branEN_4, take_4, flush_4, full_4}, 32'd0);
    chk("rst4_lookup", {addr2_4[29:22], 24'd0}, 32'd0);
    chk("rst4_next_pc", next_pc_4, 32'd4);
    tick(); tick();
    nRST = 1'b1;

    // mispredict then async reset during the flush cycle
    fetch_en = 1'b1; fetch_pc = 32'h100;
    tick();
    fetch_en = 1'b0;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h40;
    tick();
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    chk("pre_rst_redirect", next_pc, 32'h40);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    chk("mid_rst_branEN", {31'd0, branEN}, 32'd0);
    chk("mid_rst_addr1", addr1, 32'd0);
    chk("mid_rst_cnt", {16'd0, mispred_cnt}, 32'd0);
    chk("mid_rst_next_pc", next_pc, 32'h104);
    ex_valid = 1'b0;
    nRST = 1'b1;
    #1;
    chk("seq_next_pc", next_pc, 32'h104);
    chk("seq_addr2", {2'd0, addr2}, 32'h40);

    // correctly predicted taken branch
    fetch_en = 1'b1; fetch_pc = 32'h200; hit = 1'b1; pc_bran_pred = 1'b1; branaddr_out = 30'h80;
    #1;
    chk("pred_next_pc", next_pc, 32'h200);
    chk("pred_addr2", {2'd0, addr2}, 32'h80);
    tick();
    fetch_en = 1'b0; hit = 1'b0; pc_bran_pred = 1'b0;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h200;
    tick();
    ex_valid = 1'b0;
    chk("ok_flush", {31'd0, flush}, 32'd0);
    chk("ok_branEN", {31'd0, branEN}, 32'd1);
    chk("ok_take", {31'd0, take}, 32'd1);
    chk("ok_addr1", addr1, 32'h200);
    chk("ok_branaddr_in", {2'd0, branaddr_in}, 32'h80);
    tick();
    chk("ok_branEN_pulse", {31'd0, branEN}, 32'd0);

    // predicted not-taken, actually taken
    fetch_en = 1'b1; fetch_pc = 32'h300;
    tick();
    fetch_en = 1'b0; fetch_pc = 32'h304;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h400;
    tick();
    ex_valid = 1'b0;
    chk("mp_flush", {31'd0, flush}, 32'd1);
    chk("mp_next_pc", next_pc, 32'h400);
    chk("mp_cnt", {16'd0, mispred_cnt}, 32'd1);
    chk("mp_branEN", {31'd0, branEN}, 32'd1);
    chk("mp_take", {31'd0, take}, 32'd1);
    chk("mp_addr1", addr1, 32'h300);
    chk("mp_branaddr_in", {2'd0, branaddr_in}, 32'h100);
    tick();
    chk("mp_flush_done", {31'd0, flush}, 32'd0);
    chk("mp_seq_next_pc", next_pc, 32'h308);

    // non-branch predicted taken; a younger push is squashed by the flush
    fetch_en = 1'b1; fetch_pc = 32'h500; hit = 1'b1; pc_bran_pred = 1'b1; branaddr_out = 30'h10;
    tick();
    hit = 1'b0; pc_bran_pred = 1'b0; fetch_pc = 32'h600;
    ex_valid = 1'b1; ex_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
    tick();
    fetch_en = 1'b0; ex_valid = 1'b0;
    chk("nb_flush", {31'd0, flush}, 32'd1);
    chk("nb_next_pc", next_pc, 32'h504);
    chk("nb_branEN", {31'd0, branEN}, 32'd0);
    chk("nb_cnt", {16'd0, mispred_cnt}, 32'd2);
    chk("nb_addr1_hold", addr1, 32'h300);
    tick();
    ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h999;
    tick();
    ex_valid = 1'b0;
    chk("empty_pop_branEN", {31'd0, branEN}, 32'd0);
    chk("empty_pop_flush", {31'd0, flush}, 32'd0);

    // fill the queue, then pop/push around the full boundary
    fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_pc = 32'h1000 + 32'(4 * i);
      tick();
      if (i == 2) chk("fill3_full", {31'd0, full}, 32'd0);
    end
    chk("fill4_full", {31'd0, full}, 32'd1);
    fetch_pc = 32'h1010;
    tick();
    chk("drop_full", {31'd0, full}, 32'd1);
    ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b0; ex_target = 32'h0;
    fetch_pc = 32'h1014;
    tick();
    chk("popfull_addr1", addr1, 32'h1000);
    chk("popfull_branEN", {31'd0, branEN}, 32'd1);
    chk("popfull_full", {31'd0, full}, 32'd0);
    chk("popfull_flush", {31'd0, flush}, 32'd0);
    fetch_pc = 32'h1018;
    tick();
    chk("pushpop_addr1", addr1, 32'h1004);
    chk("pushpop_full", {31'd0, full}, 32'd0);
    ex_valid = 1'b0; fetch_pc = 32'h101C;
    tick();
    chk("refill_full", {31'd0, full}, 32'd1);
    fetch_en = 1'b0; ex_valid = 1'b1;
    tick(); chk("drain0_addr1", addr1, 32'h1008);
    tick(); chk("drain1_addr1", addr1, 32'h100C);
    tick(); chk("drain2_addr1", addr1, 32'h1018);
    tick(); chk("drain3_addr1", addr1, 32'h101C);
    tick();
    chk("drain_done_branEN", {31'd0, branEN}, 32'd0);
    chk("drain_done_full", {31'd0, full}, 32'd0);
    ex_valid = 1'b0;

    // 14 more mispredicts: 16 total
    for (int i = 0; i < 14; i++) begin
      fetch_en = 1'b1; fetch_pc = 32'h2000;
      tick();
      fetch_en = 1'b0;
      ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h3000;
      tick();
      ex_valid = 1'b0;
      tick();
      if (i == 12) chk("sat4_at15", {28'd0, mispred_cnt_4}, 32'hF);
    end
    chk("sat4_hold", {28'd0, mispred_cnt_4}, 32'hF);
    chk("cnt16_total", {16'd0, mispred_cnt}, 32'd16);
    chk("sat4_flush_idle", {31'd0, flush_4}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
